// File: rtl/issue_select_pkg.sv
// Shared types for the issue stage: queue packet, CDB branch-resolution broadcast,
// and helpers for index width and branch-mask resolution.
package issue_select_pkg;

    localparam int BMASK_W  = 4;
    localparam int BR_BIT_W = $clog2(BMASK_W);

    typedef struct packed {
        logic [31:0]         pc;
        logic [4:0]          rd;
        logic [BMASK_W-1:0]  bmask;
    } rs_data_pkt_t;

    typedef struct packed {
        logic                cdb_broadcast;
        logic                br_mispred;
        logic [BR_BIT_W-1:0] br_bit;
    } cdb_pkt_t;

    // A one-entry queue still needs a 1-bit index to keep port widths legal.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A correctly predicted branch no longer guards anything: drop its mask bit.
    function automatic rs_data_pkt_t apply_resolve(input rs_data_pkt_t pkt, input cdb_pkt_t cdb);
        rs_data_pkt_t res;
        res = pkt;
        if (cdb.cdb_broadcast && !cdb.br_mispred) begin
            res.bmask[cdb.br_bit] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/issue_select_if.sv
// Bundle between issue_select, the reservation-station queue, dispatch, CDB and the FU.
// master is the issue-select controller's view; slave is the surrounding datapath's view.
interface issue_select_if #(
    parameter int QUEUE_DEPTH = 3
);
    import issue_select_pkg::*;

    localparam int IW = idx_width(QUEUE_DEPTH);

    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic                   rs_station_wen;
    logic [IW-1:0]          rs_station_waddr;
    logic [QUEUE_DEPTH-1:0] rs_queue_valid_bits;
    logic [QUEUE_DEPTH-1:0] rs_ready_bits;
    logic                   rs_station_complete;
    logic [IW-1:0]          rs_station_raddr;
    rs_data_pkt_t           rs_pkt_in;
    cdb_pkt_t               cdb_pkt2;
    logic                   fu_valid;
    logic                   fu_ready;
    rs_data_pkt_t           fu_pkt;

    modport master (
        input  dispatch_valid,
        output dispatch_ready,
        output rs_station_wen,
        output rs_station_waddr,
        input  rs_queue_valid_bits,
        input  rs_ready_bits,
        output rs_station_complete,
        output rs_station_raddr,
        input  rs_pkt_in,
        input  cdb_pkt2,
        output fu_valid,
        input  fu_ready,
        output fu_pkt
    );

    modport slave (
        output dispatch_valid,
        input  dispatch_ready,
        input  rs_station_wen,
        input  rs_station_waddr,
        output rs_queue_valid_bits,
        output rs_ready_bits,
        input  rs_station_complete,
        input  rs_station_raddr,
        output rs_pkt_in,
        output cdb_pkt2,
        input  fu_valid,
        output fu_ready,
        input  fu_pkt
    );

endinterface

// File: rtl/issue_select_age_matrix_sel.sv
// Age matrix over queue slots plus oldest-ready selector; selection is combinational,
// matrix updates on the write edge. No backpressure of its own.
module issue_select_age_matrix_sel
    import issue_select_pkg::*;
#(
    parameter int QUEUE_DEPTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wen,
    input  logic [idx_width(QUEUE_DEPTH)-1:0]    waddr,
    input  logic [QUEUE_DEPTH-1:0]               ready,
    output logic                                 any_ready,
    output logic [idx_width(QUEUE_DEPTH)-1:0]    sel
);

    localparam int IW = idx_width(QUEUE_DEPTH);

    // age[i][j] = 1 : entry i is older than entry j
    logic [QUEUE_DEPTH-1:0] age [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] win;
    logic [QUEUE_DEPTH-1:0] pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                age[i] <= '0;
            end
        end else if (wen) begin
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                if (IW'(k) == waddr) begin
                    age[k] <= '0;
                end else begin
                    age[k][waddr] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        win  = '0;
        pick = '0;
        sel  = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            win[i] = ready[i];
            for (int j = 0; j < QUEUE_DEPTH; j++) begin
                if (j != i && ready[j] && !age[i][j]) begin
                    win[i] = 1'b0;
                end
            end
        end
        // Never-written slots leave the matrix without a winner; lowest ready index stands in.
        pick = (|win) ? win : ready;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                sel = IW'(i);
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/issue_select.sv
// Issue control for the reservation station: slot allocation, oldest-ready select, and a
// one-entry FU issue register (1-cycle select-to-fu_valid; stalls issue while fu_ready=0 and full).
module issue_select
    import issue_select_pkg::*;
#(
    parameter int QUEUE_DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    issue_select_if.master bus
);

    localparam int IW = idx_width(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0] free_slots;
    logic [IW-1:0]          waddr;
    logic                   wen;
    logic                   any_ready;
    logic [IW-1:0]          sel;
    logic                   can_issue;
    logic                   complete;
    logic                   squash;

    logic                   fu_vld_q;
    rs_data_pkt_t           fu_pkt_q;
    cdb_pkt_t               cdb;

    assign cdb = bus.cdb_pkt2;

    always_comb begin
        free_slots = ~bus.rs_queue_valid_bits;
        waddr      = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (free_slots[i]) begin
                waddr = IW'(i);
            end
        end
    end

    assign wen = bus.dispatch_valid & (|free_slots);

    issue_select_age_matrix_sel #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_age_sel (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .ready     (bus.rs_ready_bits),
        .any_ready (any_ready),
        .sel       (sel)
    );

    assign can_issue = ~fu_vld_q | bus.fu_ready;
    assign complete  = can_issue & any_ready;
    assign squash    = fu_vld_q & cdb.cdb_broadcast & cdb.br_mispred & fu_pkt_q.bmask[cdb.br_bit];

    always_ff @(posedge clk) begin
        if (rst) begin
            fu_vld_q <= 1'b0;
            fu_pkt_q <= '0;
        end else if (complete) begin
            fu_vld_q <= 1'b1;
            fu_pkt_q <= apply_resolve(bus.rs_pkt_in, cdb);
        end else begin
            // Held packets keep tracking resolutions even while the FU stalls.
            fu_pkt_q <= apply_resolve(fu_pkt_q, cdb);
            if (squash || bus.fu_ready) begin
                fu_vld_q <= 1'b0;
            end
        end
    end

    assign bus.dispatch_ready      = |free_slots;
    assign bus.rs_station_wen      = wen;
    assign bus.rs_station_waddr    = waddr;
    assign bus.rs_station_complete = complete;
    assign bus.rs_station_raddr    = any_ready ? sel : '0;
    assign bus.fu_valid            = fu_vld_q;
    assign bus.fu_pkt              = fu_pkt_q;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: reset-held allocation/select table, directed multi-cycle
// sequences, then randomized traffic against a sequence-number queue model.
module tb_issue_select;
    import issue_select_pkg::*;

    localparam int QD = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_select_if #(.QUEUE_DEPTH(QD)) bus ();

    issue_select #(.QUEUE_DEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Queue storage owned by the bench; read data follows raddr combinationally.
    rs_data_pkt_t qpkt [4];
    assign bus.rs_pkt_in = qpkt[bus.rs_station_raddr];

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rs_data_pkt_t mk(input logic [31:0] pc, input logic [3:0] bm);
        rs_data_pkt_t p;
        p.pc    = pc;
        p.rd    = pc[4:0];
        p.bmask = bm;
        return p;
    endfunction

    task automatic set_cdb(input logic b, input logic m, input logic [1:0] bit_i);
        cdb_pkt_t c;
        c.cdb_broadcast = b;
        c.br_mispred    = m;
        c.br_bit        = bit_i;
        bus.cdb_pkt2    = c;
    endtask

    typedef struct {
        logic       dv;
        logic [2:0] vb;
        logic [2:0] rb;
        logic       e_dr;
        logic       e_wen;
        logic [1:0] e_wa;
        logic       e_cmp;
        logic [1:0] e_ra;
    } vec_t;

    vec_t tbl [8];

    // random-phase model state
    logic [2:0]   qv, qrdy, kill, rdy;
    int           qseq [3];
    int           seq_ctr;
    logic         m_fv, n_fv;
    rs_data_pkt_t m_fu, n_fu, nv;
    logic         e_dr, e_wen, e_cmp, fr, dv;
    logic [1:0]   e_wa, e_ra;
    int           best;
    cdb_pkt_t     c;

    initial begin
        rst                     = 1'b1;
        bus.dispatch_valid      = 1'b0;
        bus.rs_queue_valid_bits = '0;
        bus.rs_ready_bits       = '0;
        bus.fu_ready            = 1'b0;
        set_cdb(1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) qpkt[i] = '0;

        step();
        step();
        chk("reset_fu_valid", 64'(bus.fu_valid), 64'd0);
        chk("reset_fu_pkt", 64'(bus.fu_pkt), 64'd0);

        // dv, valid, ready -> dispatch_ready, wen, waddr, complete, raddr (ages held clear by rst)
        tbl[0] = '{1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 3'b001, 3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 3'b011, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0};
        tbl[3] = '{1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[4] = '{1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[5] = '{1'b1, 3'b101, 3'b100, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2};
        tbl[6] = '{1'b0, 3'b110, 3'b110, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1};
        tbl[7] = '{1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0};
        for (int i = 0; i < 8; i++) begin
            bus.dispatch_valid      = tbl[i].dv;
            bus.rs_queue_valid_bits = tbl[i].vb;
            bus.rs_ready_bits       = tbl[i].rb;
            #2;
            chk($sformatf("tbl%0d_dispatch_ready", i), 64'(bus.dispatch_ready), 64'(tbl[i].e_dr));
            chk($sformatf("tbl%0d_wen", i), 64'(bus.rs_station_wen), 64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_waddr", i), 64'(bus.rs_station_waddr), 64'(tbl[i].e_wa));
            chk($sformatf("tbl%0d_complete", i), 64'(bus.rs_station_complete), 64'(tbl[i].e_cmp));
            chk($sformatf("tbl%0d_raddr", i), 64'(bus.rs_station_raddr), 64'(tbl[i].e_ra));
            step();
        end
        bus.dispatch_valid = 1'b0; bus.rs_queue_valid_bits = '0; bus.rs_ready_bits = '0;
        rst = 1'b0;
        step();

        // Write order 2, 0, 1; oldest-first issue follows write order.
        qpkt[0] = mk(32'h100, 4'h0); qpkt[1] = mk(32'h101, 4'h0); qpkt[2] = mk(32'h102, 4'h0);
        bus.dispatch_valid = 1'b1;
        bus.rs_queue_valid_bits = 3'b011; #2;
        chk("ord_waddr2", 64'(bus.rs_station_waddr), 64'd2);
        step();
        bus.rs_queue_valid_bits = 3'b100; #2;
        chk("ord_waddr0", 64'(bus.rs_station_waddr), 64'd0);
        step();
        bus.rs_queue_valid_bits = 3'b101; #2;
        chk("ord_waddr1", 64'(bus.rs_station_waddr), 64'd1);
        chk("ord_wen1", 64'(bus.rs_station_wen), 64'd1);
        step();
        bus.dispatch_valid = 1'b0;
        bus.rs_queue_valid_bits = 3'b111; bus.rs_ready_bits = 3'b111; bus.fu_ready = 1'b1; #2;
        chk("sel_raddr_a", 64'(bus.rs_station_raddr), 64'd2);
        chk("sel_complete_a", 64'(bus.rs_station_complete), 64'd1);
        step();
        chk("sel_fu_valid_a", 64'(bus.fu_valid), 64'd1);
        chk("sel_fu_pc_a", 64'(bus.fu_pkt.pc), 64'h102);
        // stall: FU not accepting, register full
        bus.rs_queue_valid_bits = 3'b011; bus.rs_ready_bits = 3'b011; bus.fu_ready = 1'b0; #2;
        chk("stall_complete", 64'(bus.rs_station_complete), 64'd0);
        step();
        chk("stall_fu_valid", 64'(bus.fu_valid), 64'd1);
        chk("stall_fu_pc", 64'(bus.fu_pkt.pc), 64'h102);
        bus.fu_ready = 1'b1; #2;
        chk("release_complete", 64'(bus.rs_station_complete), 64'd1);
        chk("sel_raddr_b", 64'(bus.rs_station_raddr), 64'd0);
        step();
        chk("sel_fu_pc_b", 64'(bus.fu_pkt.pc), 64'h100);
        bus.rs_queue_valid_bits = 3'b010; bus.rs_ready_bits = 3'b010; #2;
        chk("sel_raddr_c", 64'(bus.rs_station_raddr), 64'd1);
        step();
        chk("sel_fu_pc_c", 64'(bus.fu_pkt.pc), 64'h101);
        bus.rs_queue_valid_bits = 3'b000; bus.rs_ready_bits = 3'b000; #2;
        chk("empty_complete", 64'(bus.rs_station_complete), 64'd0);
        step();
        chk("drain_fu_valid", 64'(bus.fu_valid), 64'd0);

        // Squash a stalled op on mispredict of its branch.
        qpkt[0] = mk(32'h200, 4'b0010);
        bus.fu_ready = 1'b0; bus.rs_queue_valid_bits = 3'b001; bus.rs_ready_bits = 3'b001;
        step();
        chk("sq_load_bmask", 64'(bus.fu_pkt.bmask), 64'b0010);
        bus.rs_queue_valid_bits = 3'b000; bus.rs_ready_bits = 3'b000;
        set_cdb(1'b1, 1'b1, 2'd1);
        step();
        chk("sq_fu_valid", 64'(bus.fu_valid), 64'd0);
        set_cdb(1'b0, 1'b0, 2'd0);

        // Correct prediction clears the bit of a held op.
        bus.rs_queue_valid_bits = 3'b001; bus.rs_ready_bits = 3'b001;
        step();
        bus.rs_queue_valid_bits = 3'b000; bus.rs_ready_bits = 3'b000;
        set_cdb(1'b1, 1'b0, 2'd1);
        step();
        chk("res_fu_valid", 64'(bus.fu_valid), 64'd1);
        chk("res_bmask", 64'(bus.fu_pkt.bmask), 64'b0000);

        // Load coincident with resolve of the captured op's branch.
        qpkt[0] = mk(32'h300, 4'b0100);
        bus.fu_ready = 1'b1; bus.rs_queue_valid_bits = 3'b001; bus.rs_ready_bits = 3'b001;
        set_cdb(1'b1, 1'b0, 2'd2);
        step();
        chk("ldres_pc", 64'(bus.fu_pkt.pc), 64'h300);
        chk("ldres_bmask", 64'(bus.fu_pkt.bmask), 64'b0000);
        set_cdb(1'b0, 1'b0, 2'd0);
        bus.fu_ready = 1'b0; bus.rs_queue_valid_bits = 3'b000; bus.rs_ready_bits = 3'b000;

        // Mid-operation reset, then stale slot 0 alongside fresh slot 1.
        rst = 1'b1;
        step();
        chk("rst_fu_valid", 64'(bus.fu_valid), 64'd0);
        chk("rst_fu_pkt", 64'(bus.fu_pkt), 64'd0);
        rst = 1'b0;
        qpkt[0] = mk(32'h400, 4'h0); qpkt[1] = mk(32'h401, 4'h0);
        bus.dispatch_valid = 1'b1; bus.rs_queue_valid_bits = 3'b001; #2;
        chk("post_rst_waddr", 64'(bus.rs_station_waddr), 64'd1);
        step();
        bus.dispatch_valid = 1'b0; bus.rs_queue_valid_bits = 3'b011; bus.rs_ready_bits = 3'b011;
        bus.fu_ready = 1'b1; #2;
        chk("fallback_raddr", 64'(bus.rs_station_raddr), 64'd0);
        chk("fallback_complete", 64'(bus.rs_station_complete), 64'd1);
        step();
        chk("fallback_pc", 64'(bus.fu_pkt.pc), 64'h400);

        // Randomized traffic; oldest = smallest dispatch sequence number.
        rst = 1'b1;
        bus.rs_queue_valid_bits = '0; bus.rs_ready_bits = '0;
        step();
        rst = 1'b0;
        qv = '0; qrdy = '0; seq_ctr = 0; m_fv = 1'b0; m_fu = '0;
        for (int i = 0; i < 3; i++) qseq[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fr = ($urandom % 4) != 0;
            dv = $urandom % 2;
            c.cdb_broadcast = ($urandom % 4) == 0;
            c.br_mispred    = ($urandom % 3) == 0;
            c.br_bit        = 2'($urandom % 4);
            kill = '0;
            for (int i = 0; i < 3; i++)
                if (qv[i] && c.cdb_broadcast && c.br_mispred && qpkt[i].bmask[c.br_bit]) kill[i] = 1'b1;
            rdy = qv & qrdy & ~kill;
            bus.dispatch_valid = dv; bus.fu_ready = fr; bus.cdb_pkt2 = c;
            bus.rs_queue_valid_bits = qv; bus.rs_ready_bits = rdy;

            e_dr = (qv != 3'b111);
            e_wen = dv & e_dr;
            e_wa = 2'd0;
            for (int i = 2; i >= 0; i--) if (!qv[i]) e_wa = 2'(i);
            e_cmp = (!m_fv || fr) && (rdy != 0);
            best = -1;
            for (int i = 0; i < 3; i++)
                if (rdy[i] && (best < 0 || qseq[i] < qseq[best])) best = i;
            e_ra = (best >= 0) ? 2'(best) : 2'd0;
            #2;
            chk("rnd_dispatch_ready", 64'(bus.dispatch_ready), 64'(e_dr));
            chk("rnd_wen", 64'(bus.rs_station_wen), 64'(e_wen));
            if (e_wen) chk("rnd_waddr", 64'(bus.rs_station_waddr), 64'(e_wa));
            chk("rnd_complete", 64'(bus.rs_station_complete), 64'(e_cmp));
            chk("rnd_raddr", 64'(bus.rs_station_raddr), 64'(e_ra));

            if (e_cmp) begin
                n_fv = 1'b1;
                n_fu = qpkt[e_ra];
            end else if (m_fv && c.cdb_broadcast && c.br_mispred && m_fu.bmask[c.br_bit]) begin
                n_fv = 1'b0;
                n_fu = m_fu;
            end else begin
                n_fv = m_fv && !fr;
                n_fu = m_fu;
            end
            if (c.cdb_broadcast && !c.br_mispred && !(n_fv == 1'b0 && !e_cmp && m_fv && c.br_mispred))
                n_fu.bmask[c.br_bit] = 1'b0;
            nv = mk($urandom, 4'($urandom));

            step();
            if (e_cmp) qv[e_ra] = 1'b0;
            qv = qv & ~kill;
            if (c.cdb_broadcast && !c.br_mispred)
                for (int i = 0; i < 3; i++) qpkt[i].bmask[c.br_bit] = 1'b0;
            if (e_wen) begin
                qv[e_wa] = 1'b1; qrdy[e_wa] = 1'b0; qseq[e_wa] = seq_ctr; qpkt[e_wa] = nv;
                seq_ctr++;
            end
            for (int i = 0; i < 3; i++)
                if (qv[i] && !qrdy[i] && ($urandom % 2) == 1) qrdy[i] = 1'b1;
            m_fv = n_fv;
            m_fu = n_fu;
            chk("rnd_fu_valid", 64'(bus.fu_valid), 64'(m_fv));
            if (m_fv) chk("rnd_fu_pkt", 64'(bus.fu_pkt), 64'(m_fu));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Control stage paired with the reservation-station issue queue.
- Allocates free queue slots for dispatch and tracks entry age with an age matrix.
- Each cycle, selects the oldest ready entry, drives the queue's complete/read-address strobes, and latches the issued packet into a single-entry issue register feeding the functional unit over a valid/ready handshake.
- Squashes the issue register on branch mispredict; clears resolved branch-mask bits on correct prediction.

Parameters:
- QUEUE_DEPTH, 3, number of issue-queue entries (need not be a power of two); index width IW = $clog2(QUEUE_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_valid  in  1  rename/dispatch offers one packet this cycle
- dispatch_ready  out  1  at least one queue slot free
- rs_station_wen  out  1  write strobe to issue queue
- rs_station_waddr  out  IW  slot index written
- rs_queue_valid_bits  in  QUEUE_DEPTH  per-entry valid from queue
- rs_ready_bits  in  QUEUE_DEPTH  per-entry ready from queue (already excludes mispredict-killed entries)
- rs_station_complete  out  1  issue strobe: queue invalidates entry at raddr next edge
- rs_station_raddr  out  IW  selected entry index
- rs_pkt_in  in  rs_data_pkt_t  queue read data for rs_station_raddr (combinational)
- cdb_pkt2  in  cdb_pkt_t  branch-resolution broadcast (cdb_broadcast, br_mispred, br_bit)
- fu_valid  out  1  issue register holds a live op
- fu_ready  in  1  functional unit accepts op this cycle
- fu_pkt  out  rs_data_pkt_t  issue register contents

Behaviour:
- Reset: age matrix all 0; fu_valid=0; fu_pkt='0. Combinational outputs follow their equations from inputs and reset state.
- Allocation:
  - waddr = lowest index i < QUEUE_DEPTH with rs_queue_valid_bits[i]=0.
  - dispatch_ready = |~rs_queue_valid_bits.
  - rs_station_wen = dispatch_valid & dispatch_ready.
  - waddr is never >= QUEUE_DEPTH. When full, waddr=0 and wen=0.
  - A slot freed by issue this cycle is not reused until the next cycle (valid bits are registered).
- Age matrix: age[i][j]=1 means entry i is older than j. On wen at w: row w cleared, column w set (age[k][w]=1 for all k != w). Diagonal is ignored.
- Select:
  - sel = the i with rs_ready_bits[i]=1 and, for every other ready j, age[i][j]=1.
  - If the matrix is inconsistent (post-reset, never-written entries), fall back to the lowest ready index.
- Issue:
  - can_issue = !fu_valid | fu_ready.
  - rs_station_complete = can_issue & |rs_ready_bits.
  - rs_station_raddr = sel, or 0 when nothing is ready.
  - Zero-cycle select; the op appears on fu_pkt/fu_valid the cycle after complete.
- Issue register update (priority order):
  1. Load: if complete, fu_pkt <= rs_pkt_in with resolution applied; fu_valid <= 1.
  2. Squash: else if fu_valid & cdb_pkt2.cdb_broadcast & br_mispred & fu_pkt.bmask[br_bit], fu_valid <= 0. Applies even while stalled (fu_ready=0).
  3. Drain: else if fu_valid & fu_ready, fu_valid <= 0.
  4. Otherwise hold.
- Resolution applied to captured and held packets: on cdb_broadcast & !br_mispred, bmask[br_bit] <= 0 in the same edge.
- Simultaneous events:
  - Dispatch write and issue in the same cycle are independent (different slots, since wen targets an invalid slot).
  - A mispredict on the cycle of selection cannot select a killed entry, because rs_ready_bits excludes it.
- Reset mid-operation: the issue register is dropped and ages clear. The queue resets concurrently.

Decomposition:
- Package rv32i_types already holds rs_data_pkt_t and cdb_pkt_t. Add localparam-free helper typedef age_row_t (QUEUE_DEPTH bits) only if reused elsewhere; otherwise keep it local.
- One natural sub-module: age_matrix_sel, holding the matrix storage plus the oldest-ready one-hot/encoder, parameterised on QUEUE_DEPTH.

Test Plan:
- Dispatch three ops into an empty queue (valid bits 000 -> 001 -> 011) -> waddr 0,1,2 with wen; valid=111 -> dispatch_ready=0, wen=0 despite dispatch_valid=1.
- Slots written in order 2,0,1; all become ready together (ready=111) -> raddr=2, then 0, then 1 on successive cycles with fu_ready=1; fu_valid high one cycle after each complete.
- Hold fu_ready=0 with fu_valid=1 and ready=011 -> complete=0, fu_pkt stable. Release fu_ready -> complete=1 the same cycle, new pkt next edge.
- Stalled fu_pkt.bmask=0010; cdb_pkt2 broadcast, mispred=1, br_bit=1 -> fu_valid=0 next edge.
- Same setup with mispred=0 -> fu_valid stays 1, bmask becomes 0000.
- Load coincident with correct resolve (rs_pkt_in.bmask=0100, br_bit=2) -> captured bmask=0000.
- Assert rst with fu_valid=1 and ages populated -> next cycle fu_valid=0. Then dispatch into slot 1 only, ready=011 (slot 0 stale) -> fallback selects lowest index 0 without error.
